// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder: recovers hex digits from a multiplexed 7-segment bus once each pattern is stable
module seg_capture_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg,
    input  logic              dp,
    input  logic [NDIG-1:0]   an,
    output logic [4*NDIG-1:0] hex_out,
    output logic [NDIG-1:0]   dp_out,
    output logic [NDIG-1:0]   dig_valid,
    output logic              upd,
    output logic [2:0]        upd_idx,
    output logic              bad_pat
);
    localparam int W  = NDIG + 8;
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] SC = CW'(STABLE_CYC);
    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;
    state_t state, state_nx;
    logic [W-1:0] s1, s2, p;
    logic [CW-1:0] cnt, cnt_nx;
    logic [NDIG-1:0] s_an;
    logic s_dp, an_ok, same, cap, legal;
    logic [6:0] s_seg;
    logic [3:0] nib;
    logic [2:0] idx;
    assign s_an  = s2[W-1:8];
    assign s_dp  = s2[7];
    assign s_seg = s2[6:0];
    assign an_ok = |s_an && ~|(s_an & (s_an - NDIG'(1)));
    assign same  = s2 == p;
    always_comb begin
        cnt_nx   = '0;
        state_nx = IDLE;
        cap      = 1'b0;
        if (an_ok) begin
            cnt_nx   = (state == COUNT && same) ? cnt + 1'b1 : (state == HELD && same) ? cnt : CW'(1);
            cap      = cnt_nx == SC && !(state == HELD && same);
            state_nx = (cap || (state == HELD && same)) ? HELD : COUNT;
        end
    end
    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (s_seg)
            7'h7E: nib = 4'h0;
            7'h30: nib = 4'h1;
            7'h6D: nib = 4'h2;
            7'h79: nib = 4'h3;
            7'h33: nib = 4'h4;
            7'h5B: nib = 4'h5;
            7'h5F: nib = 4'h6;
            7'h70: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h73: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h1F: nib = 4'hB;
            7'h4E: nib = 4'hC;
            7'h3D: nib = 4'hD;
            7'h4F: nib = 4'hE;
            7'h47: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end
    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) if (s_an[i]) idx = 3'(i);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            p         <= '0;
            cnt       <= '0;
            state     <= IDLE;
            hex_out   <= '0;
            dp_out    <= '0;
            dig_valid <= '0;
            upd       <= 1'b0;
            upd_idx   <= '0;
            bad_pat   <= 1'b0;
        end else begin
            s1      <= {an, dp, seg};
            s2      <= s1;
            p       <= s2;
            state   <= state_nx;
            cnt     <= cnt_nx;
            upd     <= cap;
            bad_pat <= cap && !legal;
            if (cap) upd_idx <= idx;
            for (int i = 0; i < NDIG; i++) begin
                if (cap && s_an[i]) begin
                    dp_out[i]    <= s_dp;
                    dig_valid[i] <= legal;
                    if (legal) hex_out[4*i +: 4] <= nib;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_capture_decoder.sv
// tb_seg_capture_decoder: directed scenarios for the 7-segment capture decoder
module tb_seg_capture_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] seg = '0;
    logic dp = 1'b0;
    logic [3:0] an = '0;
    logic [15:0] hex_out;
    logic [3:0] dp_out, dig_valid;
    logic upd, bad_pat;
    logic [2:0] upd_idx;
    int errors = 0;
    int checks = 0;
    logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg_capture_decoder #(.NDIG(4), .STABLE_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dp(dp), .an(an),
        .hex_out(hex_out), .dp_out(dp_out), .dig_valid(dig_valid),
        .upd(upd), .upd_idx(upd_idx), .bad_pat(bad_pat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // runs n cycles and reports what pulses were seen, values latched at the last pulse
    task automatic hold(input int n, output int pulses, output logic [15:0] hx, output logic [3:0] dpo,
                        output logic [2:0] ix, output logic bd, output int stray);
        pulses = 0; stray = 0; hx = '0; dpo = '0; ix = '0; bd = 1'b0;
        repeat (n) begin
            tick();
            if (upd) begin
                pulses++; hx = hex_out; dpo = dp_out; ix = upd_idx; bd = bad_pat;
            end else if (bad_pat) stray++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; an = '0; seg = '0; dp = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seg = 7'h7F; dp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            an = i[0] ? 4'b0000 : 4'b0001;
            tick();
        end
        checks++; if (hex_out !== 16'h0) begin errors++; $display("FAIL rst_hex: got %h want 0000", hex_out); end
        checks++; if (dp_out !== 4'h0) begin errors++; $display("FAIL rst_dp: got %b want 0000", dp_out); end
        checks++; if (dig_valid !== 4'h0) begin errors++; $display("FAIL rst_valid: got %b want 0000", dig_valid); end
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL rst_upd: got %b want 0", upd); end
        checks++; if (upd_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", upd_idx); end
        checks++; if (bad_pat !== 1'b0) begin errors++; $display("FAIL rst_bad: got %b want 0", bad_pat); end
        an = 4'b0001; rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (upd !== 1'b0) begin errors++; $display("FAIL rst_release_upd%0d: got %b want 0", i, upd); end
        end
    endtask

    task automatic test_single();
        int pulses, stray; logic [15:0] hx; logic [3:0] dpo; logic [2:0] ix; logic bd;
        do_reset();
        an = 4'b0001; seg = 7'h30; dp = 1'b0;
        hold(5, pulses, hx, dpo, ix, bd, stray);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL single_early: got %0d pulses want 0", pulses); end
        tick();
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL single_upd_edge6: got %b want 1", upd); end
        checks++; if (upd_idx !== 3'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", upd_idx); end
        checks++; if (hex_out[3:0] !== 4'h1) begin errors++; $display("FAIL single_hex: got %h want 1", hex_out[3:0]); end
        checks++; if (dig_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b want 0001", dig_valid); end
        checks++; if (bad_pat !== 1'b0) begin errors++; $display("FAIL single_bad: got %b want 0", bad_pat); end
        hold(94, pulses, hx, dpo, ix, bd, stray);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL single_repeat: got %0d extra pulses want 0", pulses); end
    endtask

    task automatic test_sweep();
        int pulses, stray, total, bad_seen; logic [15:0] hx; logic [3:0] dpo; logic [2:0] ix; logic bd;
        total = 0; bad_seen = 0;
        an = 4'b0100;
        for (int k = 0; k < 16; k++) begin
            seg = codes[k]; dp = k[0];
            hold(8, pulses, hx, dpo, ix, bd, stray);
            total += pulses;
            bad_seen += stray + int'(bd);
            checks++; if (pulses !== 1 || hx[11:8] !== 4'(k) || ix !== 3'd2 || dpo[2] !== k[0])
                begin errors++; $display("FAIL sweep_%0d: got pulses=%0d hex=%h idx=%0d dp=%b want 1/%h/2/%b", k, pulses, hx[11:8], ix, dpo[2], 4'(k), k[0]); end
        end
        checks++; if (total !== 16) begin errors++; $display("FAIL sweep_total: got %0d want 16", total); end
        checks++; if (bad_seen !== 0) begin errors++; $display("FAIL sweep_bad: got %0d want 0", bad_seen); end
        checks++; if (hex_out[3:0] !== 4'h1) begin errors++; $display("FAIL sweep_slot0: got %h want 1", hex_out[3:0]); end
        checks++; if (dig_valid !== 4'b0101) begin errors++; $display("FAIL sweep_valid: got %b want 0101", dig_valid); end
    endtask

    task automatic test_glitch();
        int pulses, p1, stray; logic [15:0] hx; logic [3:0] dpo; logic [2:0] ix; logic bd;
        an = 4'b0010; seg = 7'h7F; dp = 1'b0;
        hold(3, p1, hx, dpo, ix, bd, stray);
        seg = 7'h73;
        hold(20, pulses, hx, dpo, ix, bd, stray);
        checks++; if (p1 + pulses !== 1) begin errors++; $display("FAIL glitch_pulses: got %0d want 1", p1 + pulses); end
        checks++; if (hx[7:4] !== 4'h9 || ix !== 3'd1) begin errors++; $display("FAIL glitch_hex: got %h idx %0d want 9 idx 1", hx[7:4], ix); end
        checks++; if (hex_out[11:8] !== 4'hF) begin errors++; $display("FAIL glitch_slot2: got %h want f", hex_out[11:8]); end
    endtask

    task automatic test_bad_pattern();
        int pulses, stray; logic [15:0] hx; logic [3:0] dpo; logic [2:0] ix; logic bd;
        seg = 7'h01;
        hold(20, pulses, hx, dpo, ix, bd, stray);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL bad_pulses: got %0d want 1", pulses); end
        checks++; if (bd !== 1'b1 || ix !== 3'd1) begin errors++; $display("FAIL bad_flag: got bad=%b idx=%0d want 1/1", bd, ix); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL bad_stray: got %0d want 0", stray); end
        checks++; if (dig_valid !== 4'b0101) begin errors++; $display("FAIL bad_valid: got %b want 0101", dig_valid); end
        checks++; if (hex_out[7:4] !== 4'h9) begin errors++; $display("FAIL bad_hex_kept: got %h want 9", hex_out[7:4]); end
    endtask

    task automatic test_enable_and_abort();
        int pulses, stray; logic [15:0] hx; logic [3:0] dpo; logic [2:0] ix; logic bd;
        an = 4'b0011; seg = 7'h30;
        hold(20, pulses, hx, dpo, ix, bd, stray);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL multi_an: got %0d pulses want 0", pulses); end
        an = 4'b0000;
        hold(20, pulses, hx, dpo, ix, bd, stray);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL zero_an: got %0d pulses want 0", pulses); end
        an = 4'b0001; seg = 7'h6D;
        hold(4, pulses, hx, dpo, ix, bd, stray);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (upd !== 1'b0 || hex_out !== 16'h0 || dig_valid !== 4'h0 || dp_out !== 4'h0)
            begin errors++; $display("FAIL abort_clear: got upd=%b hex=%h valid=%b dp=%b want all 0", upd, hex_out, dig_valid, dp_out); end
        hold(4, pulses, hx, dpo, ix, bd, stray);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_upd: got %0d pulses want 0", pulses); end
        hold(8, pulses, hx, dpo, ix, bd, stray);
        checks++; if (pulses !== 1 || hx[3:0] !== 4'h2) begin errors++; $display("FAIL abort_recover: got %0d pulses hex %h want 1/2", pulses, hx[3:0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_glitch();
        test_bad_pattern();
        test_enable_and_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
